// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - LC-3b regfile write-port arbiter with per-source result FIFOs
module regfile_writeback #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_dest,
    input  logic [15:0] mem_data,
    output logic        rf_load,
    output logic [2:0]  rf_dest,
    output logic [15:0] rf_in,
    output logic [7:0]  pending_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [2:0]    alu_dest_q [DEPTH];
    logic [15:0]   alu_data_q [DEPTH];
    logic [2:0]    mem_dest_q [DEPTH];
    logic [15:0]   mem_data_q [DEPTH];

    logic [AW-1:0] alu_wp_q, alu_wp_d, alu_rp_q, alu_rp_d;
    logic [AW-1:0] mem_wp_q, mem_wp_d, mem_rp_q, mem_rp_d;
    logic [CW-1:0] alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_load_q, rf_load_d;
    logic [2:0]    rf_dest_q, rf_dest_d;
    logic [15:0]   rf_in_q, rf_in_d;

    logic alu_push, mem_push;
    logic alu_ne, mem_ne;
    logic grant_alu, grant_mem;

    // Ready looks only at occupancy, so a full FIFO never accepts even on a pop cycle.
    assign alu_ready = !reset && !flush && (alu_cnt_q < CW'(DEPTH));
    assign mem_ready = !reset && !flush && (mem_cnt_q < CW'(DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;

    assign alu_ne    = (alu_cnt_q != '0);
    assign mem_ne    = (mem_cnt_q != '0);
    assign grant_alu = alu_ne && (!mem_ne || (starve_q == SW'(STARVE_LIMIT)));
    assign grant_mem = mem_ne && !grant_alu;

    always_comb begin
        alu_wp_d  = alu_wp_q;
        alu_rp_d  = alu_rp_q;
        mem_wp_d  = mem_wp_q;
        mem_rp_d  = mem_rp_q;
        alu_cnt_d = alu_cnt_q + CW'(alu_push) - CW'(grant_alu);
        mem_cnt_d = mem_cnt_q + CW'(mem_push) - CW'(grant_mem);
        starve_d  = starve_q;
        rf_load_d = grant_alu || grant_mem;
        rf_dest_d = rf_dest_q;
        rf_in_d   = rf_in_q;

        if (alu_push)  alu_wp_d = alu_wp_q + AW'(1);
        if (mem_push)  mem_wp_d = mem_wp_q + AW'(1);
        if (grant_alu) alu_rp_d = alu_rp_q + AW'(1);
        if (grant_mem) mem_rp_d = mem_rp_q + AW'(1);

        if (!alu_ne || grant_alu) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end

        if (grant_alu) begin
            rf_dest_d = alu_dest_q[alu_rp_q];
            rf_in_d   = alu_data_q[alu_rp_q];
        end else if (grant_mem) begin
            rf_dest_d = mem_dest_q[mem_rp_q];
            rf_in_d   = mem_data_q[mem_rp_q];
        end

        // Flush drops buffered results; a write already in the output stage
        // has been sampled by the regfile on the preceding negedge.
        if (flush) begin
            alu_wp_d  = '0;
            alu_rp_d  = '0;
            mem_wp_d  = '0;
            mem_rp_d  = '0;
            alu_cnt_d = '0;
            mem_cnt_d = '0;
            starve_d  = '0;
            rf_load_d = 1'b0;
            rf_dest_d = rf_dest_q;
            rf_in_d   = rf_in_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_wp_q  <= '0;
            alu_rp_q  <= '0;
            mem_wp_q  <= '0;
            mem_rp_q  <= '0;
            alu_cnt_q <= '0;
            mem_cnt_q <= '0;
            starve_q  <= '0;
            rf_load_q <= 1'b0;
            rf_dest_q <= '0;
            rf_in_q   <= '0;
        end else begin
            alu_wp_q  <= alu_wp_d;
            alu_rp_q  <= alu_rp_d;
            mem_wp_q  <= mem_wp_d;
            mem_rp_q  <= mem_rp_d;
            alu_cnt_q <= alu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
            starve_q  <= starve_d;
            rf_load_q <= rf_load_d;
            rf_dest_q <= rf_dest_d;
            rf_in_q   <= rf_in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_dest_q[alu_wp_q] <= alu_dest;
            alu_data_q[alu_wp_q] <= alu_data;
        end
        if (mem_push) begin
            mem_dest_q[mem_wp_q] <= mem_dest;
            mem_data_q[mem_wp_q] <= mem_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - alu_rp_q)} < alu_cnt_q) pending_mask[alu_dest_q[i]] = 1'b1;
            if ({1'b0, AW'(AW'(i) - mem_rp_q)} < mem_cnt_q) pending_mask[mem_dest_q[i]] = 1'b1;
        end
        if (rf_load_q) pending_mask[rf_dest_q] = 1'b1;
    end

    assign rf_load = rf_load_q;
    assign rf_dest = rf_dest_q;
    assign rf_in   = rf_in_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed vector bench for regfile_writeback
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [2:0]  alu_dest, mem_dest, rf_dest;
    logic [15:0] alu_data, mem_data, rf_in;
    logic        rf_load;
    logic [7:0]  pending_mask;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in), .pending_mask(pending_mask)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        av;
        logic [2:0]  ad;
        logic [15:0] adat;
        logic        mv;
        logic [2:0]  md;
        logic [15:0] mdat;
        logic        fl;
        logic        e_load;
        logic [2:0]  e_dest;
        logic [15:0] e_in;
        logic        e_ar;
        logic        e_mr;
        logic [7:0]  e_pend;
    } vec_t;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    vec_t        vecs [12];
    wr_t         wlog [$];
    logic [15:0] rf_model [8];

    // Regfile model: samples the write port on negedge, as the real regfile does.
    always @(negedge clk) begin
        if (rf_load) begin
            rf_model[rf_dest] = rf_in;
            wlog.push_back('{rf_dest, rf_in});
        end
    end

    always @(posedge clk) begin
        if (!reset && alu_valid && alu_ready && mem_valid && mem_ready && alu_dest == mem_dest)
            $error("same dest pushed by both sources");
    end

    task automatic stream_cycle(input int t, input bool_chk, inout int acc_a, inout int acc_m);
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'(32'hA000 + acc_a);
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'(32'hB000 + acc_m);
        #1;
        if (bool_chk != 0) begin
            check($sformatf("alu_ready t%0d", t), {31'd0, alu_ready},
                  (t < 2) ? 32'd1 : (t < 5) ? 32'd0 : ((t % 4) == 1 ? 32'd1 : 32'd0));
            check($sformatf("mem_ready t%0d", t), {31'd0, mem_ready},
                  (t < 5) ? 32'd1 : ((t % 4) != 1 ? 32'd1 : 32'd0));
        end
        if (alu_ready) acc_a++;
        if (mem_ready) acc_m++;
        tick();
    endtask

    initial begin
        int acc_a, acc_m, ia, im;

        for (int r = 0; r < 8; r++) rf_model[r] = 16'h0000;
        reset = 1'b1; flush = 1'b0;
        alu_valid = 1'b0; alu_dest = 3'd0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_dest = 3'd0; mem_data = 16'h0;

        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 8'h08};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b1, 8'h08};
        vecs[3]  = '{1'b1, 3'd6, 16'h0066, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0, 3'd3, 16'h1234, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 16'h1234, 1'b1, 1'b1, 8'h60};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b1, 1'b1, 8'h60};
        vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd6, 16'h0066, 1'b1, 1'b1, 8'h40};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0011, 1'b0, 1'b0, 3'd6, 16'h0066, 1'b1, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b0, 3'd6, 16'h0066, 1'b1, 1'b1, 8'h02};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd1, 16'h0011, 1'b1, 1'b1, 8'h06};
        vecs[10] = '{1'b1, 3'd7, 16'h0777, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b0, 8'h04};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 16'h0022, 1'b1, 1'b1, 8'h00};

        // Reset held two cycles with a valid ALU offer
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'hDEAD;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("reset alu_ready c%0d", c), {31'd0, alu_ready}, 32'd0);
            check($sformatf("reset rf_load c%0d", c), {31'd0, rf_load}, 32'd0);
            check($sformatf("reset pending c%0d", c), {24'd0, pending_mask}, 32'd0);
        end
        reset = 1'b0; alu_valid = 1'b0;
        tick();
        check("release alu_ready", {31'd0, alu_ready}, 32'd1);
        check("release pending", {24'd0, pending_mask}, 32'd0);

        // Table-driven single write, contention-free pair, MEM back-to-back, flush
        for (int i = 0; i < 12; i++) begin
            alu_valid = vecs[i].av; alu_dest = vecs[i].ad; alu_data = vecs[i].adat;
            mem_valid = vecs[i].mv; mem_dest = vecs[i].md; mem_data = vecs[i].mdat;
            flush     = vecs[i].fl;
            #1;
            check($sformatf("v%0d rf_load", i), {31'd0, rf_load}, {31'd0, vecs[i].e_load});
            check($sformatf("v%0d rf_dest", i), {29'd0, rf_dest}, {29'd0, vecs[i].e_dest});
            check($sformatf("v%0d rf_in", i), {16'd0, rf_in}, {16'd0, vecs[i].e_in});
            check($sformatf("v%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
            check($sformatf("v%0d mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_mr});
            check($sformatf("v%0d pending", i), {24'd0, pending_mask}, {24'd0, vecs[i].e_pend});
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; flush = 1'b0;
        check("regfile R3", {16'd0, rf_model[3]}, 32'h1234);

        // Contention, starvation and full handling
        wlog.delete();
        acc_a = 0; acc_m = 0;
        for (int t = 0; t < 16; t++) stream_cycle(t, 1, acc_a, acc_m);
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (12) tick();
        check("alu accepted", acc_a, 32'd5);
        check("mem accepted", acc_m, 32'd13);
        check("writes retired", wlog.size(), acc_a + acc_m);
        for (int i = 0; i < 12; i++)
            check($sformatf("grant %0d dest", i), (i < wlog.size()) ? {29'd0, wlog[i].dest} : 32'hFFFF,
                  ((i % 4) == 3) ? 32'd1 : 32'd2);
        ia = 0; im = 0;
        foreach (wlog[i]) begin
            if (wlog[i].dest == 3'd1) begin
                check($sformatf("alu order %0d", ia), {16'd0, wlog[i].data}, 32'hA000 + ia);
                ia++;
            end else begin
                check($sformatf("mem order %0d", im), {16'd0, wlog[i].data}, 32'hB000 + im);
                im++;
            end
        end

        // Flush with two ALU and one MEM entry buffered plus one write in the output stage
        wlog.delete();
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h0101;
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'h0202;
        tick();
        alu_dest = 3'd3; alu_data = 16'h0303;
        mem_dest = 3'd4; mem_data = 16'h0404;
        tick();
        flush = 1'b1; alu_dest = 3'd5; alu_data = 16'h0505; mem_valid = 1'b0;
        #1;
        check("flush pre pending", {24'd0, pending_mask}, 32'h1E);
        check("flush pre rf_load", {31'd0, rf_load}, 32'd1);
        check("flush alu_ready", {31'd0, alu_ready}, 32'd0);
        check("flush mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        flush = 1'b0; alu_valid = 1'b0;
        #1;
        check("flush post pending", {24'd0, pending_mask}, 32'd0);
        check("flush post rf_load", {31'd0, rf_load}, 32'd0);
        check("flush post alu_ready", {31'd0, alu_ready}, 32'd1);
        repeat (5) tick();
        check("flush writes", wlog.size(), 32'd1);
        check("flush write dest", (wlog.size() > 0) ? {29'd0, wlog[0].dest} : 32'hFFFF, 32'd2);
        check("flush write data", (wlog.size() > 0) ? {16'd0, wlog[0].data} : 32'hFFFF, 32'h0202);

        // Reset mid-operation
        acc_a = 0; acc_m = 0;
        for (int t = 0; t < 5; t++) stream_cycle(t, 0, acc_a, acc_m);
        #1;
        check("pre-reset rf_load", {31'd0, rf_load}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid reset alu_ready", {31'd0, alu_ready}, 32'd0);
        check("mid reset mem_ready", {31'd0, mem_ready}, 32'd0);
        tick();
        check("post reset rf_load", {31'd0, rf_load}, 32'd0);
        check("post reset rf_dest", {29'd0, rf_dest}, 32'd0);
        check("post reset rf_in", {16'd0, rf_in}, 32'd0);
        check("post reset pending", {24'd0, pending_mask}, 32'd0);
        wlog.delete();
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (6) tick();
        check("no stale writes", wlog.size(), 32'd0);
        check("idle pending", {24'd0, pending_mask}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
